dpr_ctrl: RTL and testbench

Sequencer for the bank of P weight DPRs feeding the systolic array. It loads a ROWS x COLS weight matrix from a valid/ready stream into the P DPRs, interleaving rows across them. On command it then streams read addresses to all DPRs in lockstep so the array receives P weight rows per cycle. It sits between the host/weight loader and the DPR bank, and drives every write-side and read-side control pin of the bank.

---
 rtl/dpr_ctrl_if.sv | 21 ++
 rtl/dpr_ctrl.sv | 260 ++++++++++++++++++++++++++
 tb/tb_dpr_ctrl.sv | 263 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/dpr_ctrl_if.sv
// Weight stream into the DPR sequencer.
// Plain valid/ready; a beat moves when both are high.
interface dpr_ctrl_if #(
  parameter int ELEMENT_BITS = 8
);
  logic                    w_valid;
  logic [ELEMENT_BITS-1:0] w_data;
  logic                    w_ready;

  modport master (
    output w_valid,
    output w_data,
    input  w_ready
  );

  modport slave (
    input  w_valid,
    input  w_data,
    output w_ready
  );
endinterface

// File: rtl/dpr_ctrl.sv
// Weight DPR bank sequencer: row-interleaved load,
// then lockstep read passes into the systolic array.
module dpr_ctrl #(
  parameter int P            = 4,
  parameter int FEATURE_BITS = 4,
  parameter int ELEMENT_BITS = 8
) (
  input  logic                      sys_clk,
  input  logic                      reset_n,
  input  logic [FEATURE_BITS-1:0]   cfg_rows,
  input  logic [FEATURE_BITS-1:0]   cfg_cols,
  input  logic                      load_start,
  input  logic                      run_start,
  input  logic                      run_stall,
  dpr_ctrl_if.slave                 w,
  output logic                      busy,
  output logic                      load_done,
  output logic                      run_done,
  output logic [2*FEATURE_BITS-1:0] address_in,
  output logic [ELEMENT_BITS-1:0]   data_in,
  output logic [P-1:0]              cs_in,
  output logic                      we_in,
  output logic [2*FEATURE_BITS-1:0] address_out,
  output logic [P-1:0]              cs_out,
  output logic                      oe_out,
  output logic                      out_valid
);

  localparam int FB = FEATURE_BITS;
  localparam int AW = 2 * FB;
  localparam int BW = AW + 1;
  localparam int PW = (P > 1) ? $clog2(P) : 1;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    RUN,
    DRAIN
  } state_t;

  state_t state_q, state_d;

  logic [FB-1:0] rows_q, rows_d;
  logic [FB-1:0] cols_q, cols_d;

  logic [FB-1:0] r_q, r_d;
  logic [FB-1:0] c_q, c_d;
  logic [PW-1:0] rp_q, rp_d;
  logic [AW-1:0] wbase_q, wbase_d;
  logic          ld_last_q, ld_last_d;

  logic [AW-1:0] a_q, a_d;
  logic [FB-1:0] ac_q, ac_d;
  logic [BW-1:0] bp_q, bp_d;
  logic          rn_last_q, rn_last_d;

  logic [FB-1:0] rows_e, cols_e;
  logic [AW-1:0] a_e;
  logic [FB-1:0] ac_e;
  logic [BW-1:0] bp_e;
  logic          issue, hs, cfg_zero;

  logic                    w_ready_d, busy_d;
  logic                    load_done_d, run_done_d;
  logic [AW-1:0]           address_in_d, address_out_d;
  logic [ELEMENT_BITS-1:0] data_in_d;
  logic [P-1:0]            cs_in_d, cs_out_d;
  logic                    we_d, oe_d;

  always_comb begin
    state_d       = state_q;
    rows_d        = rows_q;
    cols_d        = cols_q;
    r_d           = r_q;
    c_d           = c_q;
    rp_d          = rp_q;
    wbase_d       = wbase_q;
    ld_last_d     = ld_last_q;
    a_d           = a_q;
    ac_d          = ac_q;
    bp_d          = bp_q;
    rn_last_d     = rn_last_q;
    rows_e        = rows_q;
    cols_e        = cols_q;
    a_e           = a_q;
    ac_e          = ac_q;
    bp_e          = bp_q;
    issue         = 1'b0;
    w_ready_d     = 1'b0;
    load_done_d   = 1'b0;
    run_done_d    = 1'b0;
    we_d          = 1'b0;
    cs_in_d       = '0;
    address_in_d  = address_in;
    data_in_d     = data_in;
    oe_d          = 1'b0;
    cs_out_d      = '0;
    address_out_d = address_out;
    hs            = w.w_valid && w.w_ready;
    cfg_zero      = (cfg_rows == '0) || (cfg_cols == '0);

    unique case (state_q)
      IDLE: begin
        if (load_start) begin
          rows_d = cfg_rows;
          cols_d = cfg_cols;
          if (cfg_zero) begin
            load_done_d = 1'b1;
          end else begin
            state_d   = LOAD;
            w_ready_d = 1'b1;
            r_d       = '0;
            c_d       = '0;
            rp_d      = '0;
            wbase_d   = '0;
            ld_last_d = 1'b0;
          end
        end else if (run_start) begin
          rows_d = cfg_rows;
          cols_d = cfg_cols;
          if (cfg_zero) begin
            run_done_d = 1'b1;
          end else begin
            // first address goes out on the start edge
            state_d   = RUN;
            rows_e    = cfg_rows;
            cols_e    = cfg_cols;
            a_e       = '0;
            ac_e      = '0;
            bp_e      = '0;
            a_d       = '0;
            ac_d      = '0;
            bp_d      = '0;
            rn_last_d = 1'b0;
            issue     = !run_stall;
          end
        end
      end
      LOAD: begin
        if (ld_last_q) begin
          state_d     = IDLE;
          load_done_d = 1'b1;
        end else begin
          w_ready_d = 1'b1;
          if (hs) begin
            we_d         = 1'b1;
            cs_in_d      = P'(1) << rp_q;
            address_in_d = wbase_q + AW'(c_q);
            data_in_d    = w.w_data;
            if (c_q == cols_q - 1'b1) begin
              c_d = '0;
              r_d = r_q + 1'b1;
              if (rp_q == PW'(P - 1)) begin
                rp_d    = '0;
                wbase_d = wbase_q + AW'(cols_q);
              end else begin
                rp_d = rp_q + 1'b1;
              end
              if (r_q == rows_q - 1'b1) begin
                ld_last_d = 1'b1;
                w_ready_d = 1'b0;
              end
            end else begin
              c_d = c_q + 1'b1;
            end
          end
        end
      end
      RUN: begin
        if (rn_last_q) begin
          state_d    = DRAIN;
          run_done_d = 1'b1;
        end else begin
          issue = !run_stall;
        end
      end
      DRAIN: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    if (issue) begin
      oe_d          = 1'b1;
      address_out_d = a_e;
      a_d           = a_e + 1'b1;
      for (int i = 0; i < P; i++) begin
        cs_out_d[i] = (bp_e + BW'(i)) < BW'(rows_e);
      end
      if (ac_e == cols_e - 1'b1) begin
        ac_d = '0;
        bp_d = bp_e + BW'(P);
        if (bp_e + BW'(P) >= BW'(rows_e)) begin
          rn_last_d = 1'b1;
        end
      end else begin
        ac_d = ac_e + 1'b1;
      end
    end

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge sys_clk) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      rows_q      <= '0;
      cols_q      <= '0;
      r_q         <= '0;
      c_q         <= '0;
      rp_q        <= '0;
      wbase_q     <= '0;
      ld_last_q   <= 1'b0;
      a_q         <= '0;
      ac_q        <= '0;
      bp_q        <= '0;
      rn_last_q   <= 1'b0;
      w.w_ready   <= 1'b0;
      busy        <= 1'b0;
      load_done   <= 1'b0;
      run_done    <= 1'b0;
      address_in  <= '0;
      data_in     <= '0;
      cs_in       <= '0;
      we_in       <= 1'b0;
      address_out <= '0;
      cs_out      <= '0;
      oe_out      <= 1'b0;
      out_valid   <= 1'b0;
    end else begin
      state_q     <= state_d;
      rows_q      <= rows_d;
      cols_q      <= cols_d;
      r_q         <= r_d;
      c_q         <= c_d;
      rp_q        <= rp_d;
      wbase_q     <= wbase_d;
      ld_last_q   <= ld_last_d;
      a_q         <= a_d;
      ac_q        <= ac_d;
      bp_q        <= bp_d;
      rn_last_q   <= rn_last_d;
      w.w_ready   <= w_ready_d;
      busy        <= busy_d;
      load_done   <= load_done_d;
      run_done    <= run_done_d;
      address_in  <= address_in_d;
      data_in     <= data_in_d;
      cs_in       <= cs_in_d;
      we_in       <= we_d;
      address_out <= address_out_d;
      cs_out      <= cs_out_d;
      oe_out      <= oe_d;
      out_valid   <= oe_out;
    end
  end

endmodule

// File: tb/tb_dpr_ctrl.sv
// Directed bench for dpr_ctrl with write/read
// scoreboards fed from an index-based model.
module tb_dpr_ctrl;
  localparam int P  = 4;
  localparam int FB = 4;
  localparam int EB = 8;
  localparam int AW = 2 * FB;

  logic          sys_clk = 1'b0;
  logic          reset_n = 1'b0;
  logic [FB-1:0] cfg_rows = '0;
  logic [FB-1:0] cfg_cols = '0;
  logic          load_start = 1'b0;
  logic          run_start = 1'b0;
  logic          run_stall = 1'b0;
  logic          busy, load_done, run_done;
  logic [AW-1:0] address_in, address_out;
  logic [EB-1:0] data_in;
  logic [P-1:0]  cs_in, cs_out;
  logic          we_in, oe_out, out_valid;

  always #5 sys_clk = ~sys_clk;

  dpr_ctrl_if #(.ELEMENT_BITS(EB)) wif ();

  dpr_ctrl #(
    .P(P),
    .FEATURE_BITS(FB),
    .ELEMENT_BITS(EB)
  ) dut (
    .sys_clk    (sys_clk),
    .reset_n    (reset_n),
    .cfg_rows   (cfg_rows),
    .cfg_cols   (cfg_cols),
    .load_start (load_start),
    .run_start  (run_start),
    .run_stall  (run_stall),
    .w          (wif.slave),
    .busy       (busy),
    .load_done  (load_done),
    .run_done   (run_done),
    .address_in (address_in),
    .data_in    (data_in),
    .cs_in      (cs_in),
    .we_in      (we_in),
    .address_out(address_out),
    .cs_out     (cs_out),
    .oe_out     (oe_out),
    .out_valid  (out_valid)
  );

  int n_tests = 0;
  int n_fail  = 0;

  logic [P+AW+EB-1:0] wrq[$];
  logic [AW+P-1:0]    rdq[$];

  int   mr = 0, mc = 0, mcols = 1;
  bit   mon_en = 1'b0;
  bit   hs_prev = 1'b0;
  bit   oe_prev = 1'b0;
  logic [P+AW+EB-1:0] we_exp;
  logic [AW+P-1:0]    rd_exp;
  logic [P-1:0]       m_cs;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step;
    @(posedge sys_clk);
    #1;
  endtask

  task automatic push_reads(input int rows, input int cols);
    int blk;
    logic [P-1:0] m;
    blk = (rows + P - 1) / P;
    for (int a = 0; a < blk * cols; a++) begin
      for (int i = 0; i < P; i++) m[i] = ((a / cols) * P + i) < rows;
      rdq.push_back({AW'(a), m});
    end
  endtask

  task automatic rst_check(input string tag);
    chk({tag, "_ctl"},
        {17'd0, wif.w_ready, busy, load_done, run_done,
         we_in, oe_out, out_valid, cs_in, cs_out}, 32'd0);
    chk({tag, "_bus"},
        {8'd0, address_in, data_in, address_out}, 32'd0);
  endtask

  // scoreboard monitor, sampled mid-cycle
  always @(negedge sys_clk) begin
    if (mon_en) begin
      chk("we_timing", {31'd0, we_in}, {31'd0, hs_prev});
      if (we_in) begin
        if (wrq.size() == 0) chk("wr_extra", 1, 0);
        else begin
          we_exp = wrq.pop_front();
          chk("wr_beat", {12'd0, cs_in, address_in, data_in},
              {12'd0, we_exp});
        end
      end
      chk("ov_timing", {31'd0, out_valid}, {31'd0, oe_prev});
      if (oe_out) begin
        if (rdq.size() == 0) chk("rd_extra", 1, 0);
        else begin
          rd_exp = rdq.pop_front();
          chk("rd_addr_cs", {20'd0, address_out, cs_out},
              {20'd0, rd_exp});
        end
      end
      if (wif.w_valid && wif.w_ready) begin
        m_cs = '0;
        m_cs[mr % P] = 1'b1;
        wrq.push_back({m_cs, AW'((mr / P) * mcols + mc), wif.w_data});
        mc++;
        if (mc == mcols) begin
          mc = 0;
          mr++;
        end
      end
    end
    hs_prev = wif.w_valid && wif.w_ready && reset_n;
    oe_prev = oe_out && reset_n;
  end

  task automatic run_pass(input int rows, input int cols,
                          input int stall_at, input int stall_len);
    int n, cyc, ov;
    bit done, stall_prev;
    n = ((rows + P - 1) / P) * cols;
    push_reads(rows, cols);
    cfg_rows  = FB'(rows);
    cfg_cols  = FB'(cols);
    run_start = 1'b1;
    step;
    run_start = 1'b0;
    chk("run_first_oe", {31'd0, oe_out}, 1);
    chk("run_first_addr", {24'd0, address_out}, 0);
    chk("run_busy", {31'd0, busy}, 1);
    cyc = 1; ov = 0; done = 1'b0; stall_prev = 1'b0;
    while (cyc < 200) begin
      if (out_valid) ov++;
      if (stall_prev) chk("stall_oe", {31'd0, oe_out}, 0);
      if (done) begin
        chk("run_busy_end", {31'd0, busy}, 0);
        break;
      end
      if (run_done) begin
        done = 1'b1;
        chk("done_with_valid", {31'd0, out_valid}, 1);
        chk("ov_count", ov, n);
        chk("done_cycle", cyc, n + 1 + stall_len);
        chk("done_busy", {31'd0, busy}, 1);
      end
      run_stall  = (cyc >= stall_at) && (cyc < stall_at + stall_len);
      stall_prev = run_stall;
      step;
      cyc++;
    end
    run_stall = 1'b0;
    if (!done) chk("run_timeout", 0, 1);
    chk("rdq_empty", rdq.size(), 0);
  endtask

  initial begin
    int k, cyc, gap_cnt;
    bit hs, gap;
    wif.w_valid = 1'b0;
    wif.w_data  = '0;
    step;
    step;
    rst_check("reset");
    reset_n = 1'b1;
    mon_en  = 1'b1;

    // load 6x3; simultaneous run_start must be dropped
    cfg_rows = 4'd6; cfg_cols = 4'd3;
    mr = 0; mc = 0; mcols = 3;
    load_start = 1'b1; run_start = 1'b1;
    step;
    load_start = 1'b0; run_start = 1'b0;
    chk("load_busy", {31'd0, busy}, 1);
    chk("load_wready", {31'd0, wif.w_ready}, 1);
    k = 0; cyc = 0; gap_cnt = 0;
    while (k < 18 && cyc < 200) begin
      gap = (k == 9) && (gap_cnt < 3);
      wif.w_valid = !gap;
      wif.w_data  = EB'(k);
      run_start   = (cyc == 4);
      hs = wif.w_valid && wif.w_ready;
      step;
      cyc++;
      if (gap) gap_cnt++;
      if (hs) k++;
    end
    wif.w_valid = 1'b0;
    run_start   = 1'b0;
    if (k < 18) chk("load_timeout", k, 18);
    chk("last_cs", {28'd0, cs_in}, 32'h2);
    chk("last_addr", {24'd0, address_in}, 5);
    chk("last_data", {24'd0, data_in}, 17);
    chk("last_we", {31'd0, we_in}, 1);
    chk("wready_drop", {31'd0, wif.w_ready}, 0);
    chk("busy_t1", {31'd0, busy}, 1);
    chk("load_done_t1", {31'd0, load_done}, 0);
    step;
    chk("load_done_t2", {31'd0, load_done}, 1);
    chk("busy_t2", {31'd0, busy}, 0);
    step;
    chk("load_done_pulse", {31'd0, load_done}, 0);
    chk("wrq_empty", wrq.size(), 0);

    run_pass(6, 3, 3, 2);

    // zero rows on load
    cfg_rows = 4'd0; cfg_cols = 4'd3; load_start = 1'b1;
    step;
    load_start = 1'b0;
    chk("zero_ld_done", {31'd0, load_done}, 1);
    chk("zero_ld_busy", {31'd0, busy}, 0);
    chk("zero_ld_wready", {31'd0, wif.w_ready}, 0);
    step;
    chk("zero_ld_pulse", {31'd0, load_done}, 0);
    chk("zero_ld_we", {31'd0, we_in}, 0);

    // zero cols on run
    cfg_rows = 4'd3; cfg_cols = 4'd0; run_start = 1'b1;
    step;
    run_start = 1'b0;
    chk("zero_rd_done", {31'd0, run_done}, 1);
    chk("zero_rd_oe", {31'd0, oe_out}, 0);
    chk("zero_rd_busy", {31'd0, busy}, 0);

    run_pass(5, 2, 0, 0);

    // reset in the middle of a run
    push_reads(6, 3);
    cfg_rows = 4'd6; cfg_cols = 4'd3; run_start = 1'b1;
    step;
    run_start = 1'b0;
    step;
    step;
    reset_n = 1'b0;
    step;
    rst_check("midrun_rst");
    reset_n = 1'b1;
    rdq.delete();
    run_pass(6, 3, 0, 0);

    step;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
